// File: rtl/cpu_run_sequencer_if.sv
// Host-side bus of the run sequencer: control, load stream, CPU memory
// ports, CPU enable and dump stream, bundled for a single port connection.
interface cpu_run_sequencer_if #(
    parameter int CNT_W = 32
);
    // Run control
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] run_cycles;
    logic [9:0]       dump_base;
    logic [10:0]      dump_len;

    // Load stream
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_last;

    // Instruction-memory external port
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;

    // Data-memory external port
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2;

    // CPU enable
    logic             cpu_enable;

    // Dump stream
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_last;

    // Status
    logic             busy;
    logic             done;
    logic             err;

    // Host / CPU-model side
    modport master (
        output start, abort, run_cycles, dump_base, dump_len,
        output in_valid, in_data, in_last, rdata_ext_2, out_ready,
        input  in_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        input  cpu_enable, out_valid, out_data, out_last, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  start, abort, run_cycles, dump_base, dump_len,
        input  in_valid, in_data, in_last, rdata_ext_2, out_ready,
        output in_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        output cpu_enable, out_valid, out_data, out_last, busy, done, err
    );
endinterface

// File: rtl/cpu_run_sequencer.sv
// Sequences the CPU through one test run: stream program and data into the
// memories, hold enable for a programmed number of cycles, then read back a
// window of data memory onto the dump stream.
module cpu_run_sequencer #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              arst,
    cpu_run_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(IMEM_WORDS > DMEM_WORDS ? IMEM_WORDS : DMEM_WORDS);
    // Dump index width matches the 10-bit dump_base, so base+k wraps modulo DMEM_WORDS.
    localparam int DA_W  = 10;

    localparam logic [IDX_W-1:0] IMEM_LAST = IDX_W'(IMEM_WORDS - 1);
    localparam logic [IDX_W-1:0] DMEM_LAST = IDX_W'(DMEM_WORDS - 1);
    localparam logic [10:0]      LEN_MAX   = 11'(DMEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [10:0]      k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [DA_W-1:0]  base_q, base_d;
    logic [10:0]      len_q, len_d;
    logic             err_q, err_d;
    logic [63:0]      data_q, data_d;
    // Set once the read word has been captured into data_q.
    logic             pres_q, pres_d;

    logic [DA_W-1:0]  dump_idx;
    logic [10:0]      len_clamped;

    logic             in_ready;
    logic [63:0]      im_addr;
    logic             im_wen;
    logic [31:0]      im_wdata;
    logic [63:0]      dm_addr;
    logic             dm_wen;
    logic             dm_ren;
    logic [63:0]      dm_wdata;
    logic             cpu_en;
    logic             out_valid;
    logic [63:0]      out_data;
    logic             out_last;

    assign dump_idx    = base_q + k_q[DA_W-1:0];
    assign len_clamped = (bus.dump_len > LEN_MAX) ? LEN_MAX : bus.dump_len;

    // State and datapath registers; async reset returns everything to IDLE/zero.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            pres_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            base_q  <= base_d;
            len_q   <= len_d;
            err_q   <= err_d;
            data_q  <= data_d;
            pres_q  <= pres_d;
        end
    end

    // Next-state and output decode; abort overrides every transition last.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        base_d    = base_q;
        len_d     = len_q;
        err_d     = err_q;
        data_d    = data_q;
        pres_d    = pres_q;

        in_ready  = 1'b0;
        im_addr   = '0;
        im_wen    = 1'b0;
        im_wdata  = '0;
        dm_addr   = '0;
        dm_wen    = 1'b0;
        dm_ren    = 1'b0;
        dm_wdata  = '0;
        cpu_en    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_LOAD_I;
                    idx_d   = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    pres_d  = 1'b0;
                    run_d   = bus.run_cycles;
                    base_d  = bus.dump_base;
                    len_d   = len_clamped;
                end
            end
            S_LOAD_I: begin
                in_ready = 1'b1;
                im_wen   = bus.in_valid;
                im_addr  = 64'(idx_q) << 2;
                im_wdata = bus.in_data[31:0];
                if (bus.in_valid) begin
                    if (bus.in_last) begin
                        idx_d   = '0;
                        state_d = S_LOAD_D;
                    end else if (idx_q == IMEM_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LOAD_D: begin
                in_ready = 1'b1;
                dm_wen   = bus.in_valid;
                dm_addr  = 64'(idx_q) << 3;
                dm_wdata = bus.in_data;
                if (bus.in_valid) begin
                    if (bus.in_last) begin
                        idx_d = '0;
                        if (run_q == '0) begin
                            state_d = S_DUMP_RD;
                        end else begin
                            cnt_d   = run_q;
                            state_d = S_RUN;
                        end
                    end else if (idx_q == DMEM_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                cpu_en = 1'b1;
                cnt_d  = cnt_q - 1'b1;
                // Leaving on the count of 1 gives exactly run_cycles enabled cycles.
                if (cnt_q <= CNT_ONE) begin
                    state_d = (len_q == '0) ? S_DONE : S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                if (len_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    dm_ren  = 1'b1;
                    dm_addr = 64'(dump_idx) << 3;
                    pres_d  = 1'b0;
                    state_d = S_DUMP_OUT;
                end
            end
            S_DUMP_OUT: begin
                out_valid = 1'b1;
                out_last  = (k_q == len_q - 1'b1);
                // First cycle forwards the fresh read data; after that the captured copy holds.
                out_data  = pres_q ? data_q : bus.rdata_ext_2;
                if (!pres_q) begin
                    data_d = bus.rdata_ext_2;
                    pres_d = 1'b1;
                end
                if (bus.out_ready) begin
                    pres_d  = 1'b0;
                    k_d     = k_q + 1'b1;
                    state_d = out_last ? S_DONE : S_DUMP_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            k_d     = '0;
            cnt_d   = '0;
            run_d   = '0;
            base_d  = '0;
            len_d   = '0;
            err_d   = 1'b0;
            pres_d  = 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.addr_ext    = im_addr;
    assign bus.wen_ext     = im_wen;
    assign bus.ren_ext     = 1'b0;
    assign bus.wdata_ext   = im_wdata;
    assign bus.addr_ext_2  = dm_addr;
    assign bus.wen_ext_2   = dm_wen;
    assign bus.ren_ext_2   = dm_ren;
    assign bus.wdata_ext_2 = dm_wdata;
    assign bus.cpu_enable  = cpu_en;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_last    = out_last;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: scoreboard queues of expected memory
// writes, dump reads and dump words, checked by a negedge monitor.
module tb_cpu_run_sequencer;
    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    cpu_run_sequencer_if #(.CNT_W(32)) bus();

    cpu_run_sequencer #(
        .IMEM_WORDS (4),
        .DMEM_WORDS (1024),
        .CNT_W      (32)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
        logic        l;
    } ev_t;

    ev_t  q_iw[$];
    ev_t  q_dw[$];
    ev_t  q_rd[$];
    ev_t  q_out[$];

    int nvec   = 0;
    int nerr   = 0;
    int en_cnt = 0;

    logic [31:0] iw [8];
    logic [63:0] dw [8];
    logic [63:0] exp_mem [1024];

    // Data-memory model seen by the DUT
    logic [63:0] mem [1024];
    bit   [1023:0] wr_valid;
    logic stall_q = 1'b0;
    logic [63:0] hold_d = '0;

    function automatic logic [63:0] pat(input logic [9:0] i);
        return {32'hC0DE0000, 22'h0, i};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.wen_ext_2) begin
            mem[bus.addr_ext_2[12:3]]      <= bus.wdata_ext_2;
            wr_valid[bus.addr_ext_2[12:3]] <= 1'b1;
        end
        if (bus.ren_ext_2)
            bus.rdata_ext_2 <= wr_valid[bus.addr_ext_2[12:3]] ? mem[bus.addr_ext_2[12:3]]
                                                              : pat(bus.addr_ext_2[12:3]);
    end

    // Monitor: every DUT memory/dump event must match the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (bus.cpu_enable) en_cnt++;
        if (bus.ren_ext) chk("ren_ext_zero", 64'(bus.ren_ext), 64'd0);
        if (bus.wen_ext) begin
            if (q_iw.size() == 0) chk("imem_unexpected_wr", 64'(bus.wen_ext), 64'd0);
            else begin
                e = q_iw.pop_front();
                chk("imem_addr", bus.addr_ext, e.a);
                chk("imem_data", 64'(bus.wdata_ext), e.d);
            end
        end
        if (bus.wen_ext_2) begin
            if (q_dw.size() == 0) chk("dmem_unexpected_wr", 64'(bus.wen_ext_2), 64'd0);
            else begin
                e = q_dw.pop_front();
                chk("dmem_addr", bus.addr_ext_2, e.a);
                chk("dmem_data", bus.wdata_ext_2, e.d);
            end
        end
        if (bus.ren_ext_2) begin
            if (q_rd.size() == 0) chk("dump_unexpected_rd", 64'(bus.ren_ext_2), 64'd0);
            else begin
                e = q_rd.pop_front();
                chk("dump_rd_addr", bus.addr_ext_2, e.a);
            end
        end
        if (bus.out_valid && stall_q) chk("out_stable", bus.out_data, hold_d);
        if (bus.out_valid && bus.out_ready) begin
            if (q_out.size() == 0) chk("out_unexpected", 64'(bus.out_valid), 64'd0);
            else begin
                e = q_out.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("out_last", 64'(bus.out_last), 64'(e.l));
            end
        end
        stall_q = bus.out_valid && !bus.out_ready;
        hold_d  = bus.out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int run, input int base, input int len);
        en_cnt         = 0;
        bus.start      = 1'b1;
        bus.run_cycles = 32'(run);
        bus.dump_base  = 10'(base);
        bus.dump_len   = 11'(len);
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic load_phase(input int ni, input int nd);
        for (int i = 0; i < ni; i++) begin
            q_iw.push_back('{a: 64'(i * 4), d: {32'h0, iw[i]}, l: 1'b0});
            bus.in_valid = 1'b1;
            bus.in_data  = {32'hA5A5A5A5, iw[i]};
            bus.in_last  = (i == ni - 1);
            tick();
        end
        for (int i = 0; i < nd; i++) begin
            exp_mem[i] = dw[i];
            q_dw.push_back('{a: 64'(i * 8), d: dw[i], l: 1'b0});
            bus.in_valid = 1'b1;
            bus.in_data  = dw[i];
            bus.in_last  = (i == nd - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push_dump(input int base, input int len);
        int n;
        int ix;
        n = (len > 1024) ? 1024 : len;
        for (int k = 0; k < n; k++) begin
            ix = (base + k) % 1024;
            q_rd.push_back('{a: 64'(ix * 8), d: 64'd0, l: 1'b0});
            q_out.push_back('{a: 64'd0, d: exp_mem[ix], l: (k == n - 1)});
        end
    endtask

    task automatic wait_done(input bit toggle);
        int cyc;
        cyc = 0;
        while (!bus.done && cyc < 6000) begin
            bus.out_ready = toggle ? (cyc % 3 == 2) : 1'b1;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
        chk("done_reached", 64'(bus.done), 64'd1);
    endtask

    task automatic check_queues(input string tag);
        chk({tag, "_imem_left"}, 64'(q_iw.size()), 64'd0);
        chk({tag, "_dmem_left"}, 64'(q_dw.size()), 64'd0);
        chk({tag, "_rd_left"},   64'(q_rd.size()), 64'd0);
        chk({tag, "_out_left"},  64'(q_out.size()), 64'd0);
    endtask

    task automatic run_seq(input string tag, input int ni, input int nd, input int run,
                           input int base, input int len, input bit toggle);
        do_start(run, base, len);
        load_phase(ni, nd);
        push_dump(base, len);
        wait_done(toggle);
        chk({tag, "_en_cycles"}, 64'(en_cnt), 64'(run));
        chk({tag, "_err"},  64'(bus.err), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_queues(tag);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.run_cycles = 0; bus.dump_base = 0; bus.dump_len = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.out_ready = 1;
        for (int i = 0; i < 1024; i++) exp_mem[i] = pat(10'(i));
        iw[0] = 32'h00000013; iw[1] = 32'h00100093; iw[2] = 32'h00208113; iw[3] = 32'h00000073;
        dw[0] = 64'h11; dw[1] = 64'h22; dw[2] = 64'h33;

        // Reset state
        #2;
        chk("rst_in_ready",   64'(bus.in_ready), 64'd0);
        chk("rst_busy",       64'(bus.busy), 64'd0);
        chk("rst_done",       64'(bus.done), 64'd0);
        chk("rst_err",        64'(bus.err), 64'd0);
        chk("rst_cpu_enable", 64'(bus.cpu_enable), 64'd0);
        chk("rst_out_valid",  64'(bus.out_valid), 64'd0);
        chk("rst_wen",        64'(bus.wen_ext), 64'd0);
        chk("rst_wen2",       64'(bus.wen_ext_2), 64'd0);
        chk("rst_ren2",       64'(bus.ren_ext_2), 64'd0);
        chk("rst_addr",       bus.addr_ext, 64'd0);
        chk("rst_addr2",      bus.addr_ext_2, 64'd0);
        repeat (2) tick();
        arst = 1'b0;
        tick();

        // Basic run: 3 IMEM words, 2 DMEM words, 10 cycles, dump 2
        run_seq("basic", 3, 2, 10, 0, 2, 1'b0);

        // Stalled dump with out_ready pattern 0,0,1
        run_seq("stall", 1, 3, 2, 0, 3, 1'b1);

        // IMEM overflow: 4 words without in_last, then one extra valid beat
        do_start(5, 0, 2);
        for (int i = 0; i < 4; i++) begin
            q_iw.push_back('{a: 64'(i * 4), d: {32'h0, iw[i]}, l: 1'b0});
            bus.in_valid = 1'b1;
            bus.in_data  = {32'h5A5A5A5A, iw[i]};
            bus.in_last  = 1'b0;
            tick();
        end
        tick();
        bus.in_valid = 1'b0;
        chk("ovf_err",      64'(bus.err), 64'd1);
        chk("ovf_done",     64'(bus.done), 64'd1);
        chk("ovf_in_ready", 64'(bus.in_ready), 64'd0);
        chk("ovf_en",       64'(en_cnt), 64'd0);
        check_queues("ovf");

        // No run, no dump
        run_seq("zero", 1, 1, 0, 0, 0, 1'b0);

        // Dump window wrapping past the top of data memory
        run_seq("wrap", 1, 1, 0, 1022, 4, 1'b0);

        // Oversized dump length is clamped to the full memory
        run_seq("clamp", 1, 1, 1, 5, 2047, 1'b0);

        // Abort in the fifth RUN cycle
        do_start(20, 0, 1);
        load_phase(1, 1);
        for (int i = 0; i < 50 && !bus.cpu_enable; i++) @(negedge clk);
        chk("abort_run_seen", 64'(bus.cpu_enable), 64'd1);
        repeat (4) @(posedge clk);
        #1 bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy",   64'(bus.busy), 64'd0);
        chk("abort_done",   64'(bus.done), 64'd0);
        chk("abort_enable", 64'(bus.cpu_enable), 64'd0);
        chk("abort_en_cnt", 64'(en_cnt), 64'd5);
        tick();
        run_seq("post_abort", 2, 2, 4, 0, 2, 1'b0);

        // Asynchronous reset in the middle of the IMEM load
        do_start(6, 0, 1);
        for (int i = 0; i < 2; i++) begin
            q_iw.push_back('{a: 64'(i * 4), d: {32'h0, iw[i]}, l: 1'b0});
            bus.in_valid = 1'b1;
            bus.in_data  = {32'h0, iw[i]};
            bus.in_last  = 1'b0;
            tick();
        end
        bus.in_data = {32'h0, iw[2]};
        #1 arst = 1'b1;
        #1;
        chk("arst_wen",      64'(bus.wen_ext), 64'd0);
        chk("arst_busy",     64'(bus.busy), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("arst_enable",   64'(bus.cpu_enable), 64'd0);
        bus.in_valid = 1'b0;
        tick();
        arst = 1'b0;
        tick();
        run_seq("post_arst", 3, 2, 10, 0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
